// File: rtl/string_led_pkg.sv
// Shared types and constants for the one-wire LED-string receiver.
package string_led_pkg;

  typedef enum logic [1:0] {StSync, StIdle, StLow, StHigh} state_e;

  localparam int unsigned BitsPerLed = 24;

  // Default pulse timing at a 40 MHz system clock
  localparam int unsigned DefMinHigh     = 4;
  localparam int unsigned DefBitThresh   = 24;
  localparam int unsigned DefMaxHigh     = 48;
  localparam int unsigned DefResetCycles = 2000;

endpackage

// File: rtl/string_led_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags and simultaneous push/pop.
module string_led_fifo #(
  parameter int unsigned Width = 25,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthC = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthC);
  assign data_o  = mem_q[rd_ptr_q];

  // A push on a full FIFO is accepted only when the head leaves in the same cycle
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/string_led_receiver.sv
// WS2812-style NRZ receiver: classifies high pulse widths into bits, packs 24-bit
// pixel words, detects frame ends on the reset low, and queues words in a FIFO.
module string_led_receiver
  import string_led_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BITS_PER_LED = BitsPerLed
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    enable_i,
  input  logic                    din_i,
  input  logic [CNT_W-1:0]        cfg_min_high_i,
  input  logic [CNT_W-1:0]        cfg_bit_thresh_i,
  input  logic [CNT_W-1:0]        cfg_max_high_i,
  input  logic [CNT_W-1:0]        cfg_reset_cycles_i,
  input  logic                    clr_err_i,
  output logic [BITS_PER_LED-1:0] pix_data_o,
  output logic                    pix_first_o,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i,
  output logic                    frame_done_o,
  output logic                    err_timing_o,
  output logic                    err_partial_o,
  output logic                    err_overflow_o
);

  localparam int unsigned BcW = $clog2(BITS_PER_LED);
  localparam logic [BcW-1:0] LastBit = BcW'(BITS_PER_LED - 1);

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, line_q, rise_q, fall_q;
  logic [CNT_W-1:0]        low_q, low_d, high_q, high_d, low_inc, high_inc;
  logic [BcW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_LED-1:0] word_q, word_d, word_shift;
  logic                    first_q, first_d, pushed_q, pushed_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_timing_q, err_partial_q, err_overflow_q;
  logic                    set_timing, set_partial, set_overflow;
  logic                    push, pop, fifo_full, fifo_empty;
  logic [BITS_PER_LED:0]   fifo_head;

  assign low_inc    = (&low_q) ? low_q : low_q + CNT_W'(1);
  assign high_inc   = (&high_q) ? high_q : high_q + CNT_W'(1);
  assign word_shift = {word_q[BITS_PER_LED-2:0], (high_inc > cfg_bit_thresh_i)};

  always_comb begin
    state_d      = state_q;
    low_d        = low_q;
    high_d       = high_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    first_d      = first_q;
    pushed_d     = pushed_q;
    frame_done_d = 1'b0;
    set_timing   = 1'b0;
    set_partial  = 1'b0;
    push         = 1'b0;
    if (!enable_i) begin
      state_d   = StSync;
      low_d     = '0;
      bit_cnt_d = '0;
      word_d    = '0;
      pushed_d  = 1'b0;
    end else begin
      unique case (state_q)
        StSync: begin
          if (line_q) begin
            low_d = '0;
          end else begin
            low_d = low_inc;
            if (low_inc >= cfg_reset_cycles_i) begin
              state_d = StIdle;
              first_d = 1'b1;
            end
          end
        end
        StIdle, StLow: begin
          if (rise_q) begin
            state_d = StHigh;
            high_d  = '0;
            low_d   = '0;
          end else begin
            low_d = low_inc;
            // Frame end fires once: leaving LOW for IDLE stops re-triggering
            if (state_q == StLow && low_inc >= cfg_reset_cycles_i) begin
              state_d      = StIdle;
              set_partial  = (bit_cnt_q != '0);
              bit_cnt_d    = '0;
              word_d       = '0;
              frame_done_d = pushed_q;
              pushed_d     = 1'b0;
              first_d      = 1'b1;
            end
          end
        end
        StHigh: begin
          high_d = high_inc;
          if (high_inc > cfg_max_high_i) begin
            set_timing = 1'b1;
            state_d    = StSync;
            low_d      = '0;
            bit_cnt_d  = '0;
            word_d     = '0;
            pushed_d   = 1'b0;
          end else if (fall_q) begin
            state_d = StLow;
            low_d   = '0;
            if (high_inc < cfg_min_high_i) begin
              set_timing = 1'b1;
            end else if (bit_cnt_q == LastBit) begin
              push      = 1'b1;
              first_d   = 1'b0;
              pushed_d  = 1'b1;
              bit_cnt_d = '0;
              word_d    = '0;
            end else begin
              word_d    = word_shift;
              bit_cnt_d = bit_cnt_q + BcW'(1);
            end
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  assign pop          = pix_valid_o & pix_ready_i;
  assign set_overflow = push & fifo_full & ~pop;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      line_q         <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      state_q        <= StSync;
      low_q          <= '0;
      high_q         <= '0;
      bit_cnt_q      <= '0;
      word_q         <= '0;
      first_q        <= 1'b0;
      pushed_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      err_timing_q   <= 1'b0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      sync1_q        <= din_i;
      sync2_q        <= sync1_q;
      line_q         <= sync2_q;
      rise_q         <= sync2_q & ~line_q;
      fall_q         <= ~sync2_q & line_q;
      state_q        <= state_d;
      low_q          <= low_d;
      high_q         <= high_d;
      bit_cnt_q      <= bit_cnt_d;
      word_q         <= word_d;
      first_q        <= first_d;
      pushed_q       <= pushed_d;
      frame_done_q   <= frame_done_d;
      err_timing_q   <= (err_timing_q & ~clr_err_i) | set_timing;
      err_partial_q  <= (err_partial_q & ~clr_err_i) | set_partial;
      err_overflow_q <= (err_overflow_q & ~clr_err_i) | set_overflow;
    end
  end

  string_led_fifo #(
    .Width (BITS_PER_LED + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push),
    .data_i  ({first_q, word_shift}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Gate the head so the outputs read zero whenever nothing is queued
  assign pix_valid_o    = ~fifo_empty;
  assign pix_data_o     = pix_valid_o ? fifo_head[BITS_PER_LED-1:0] : '0;
  assign pix_first_o    = pix_valid_o & fifo_head[BITS_PER_LED];
  assign frame_done_o   = frame_done_q;
  assign err_timing_o   = err_timing_q;
  assign err_partial_o  = err_partial_q;
  assign err_overflow_o = err_overflow_q;

endmodule

// File: doc/string_led_receiver.md
Name: string_led_receiver

Overview:
One-wire LED-string decoder (WS2812-style NRZ pulse-width protocol). It is the receive side of the string LED controller's serial output. It samples the LED data line and classifies each high pulse as a 0 or 1 bit. Bits are assembled into 24-bit pixel words, and frame boundaries are detected on the reset low period. Words are delivered through a small valid/ready FIFO to the Wishbone-side logic in the user project area, for loopback self-test or for chaining an external string back into the SoC.

Parameters:
CNT_W, 16, width of the pulse-width counters and cfg_* inputs
FIFO_DEPTH, 4, pixel FIFO depth (power of 2, at least 2)
BITS_PER_LED, 24, bits per pixel word

Ports:
wb_clk_i  in  1  single system clock
wb_rst_i  in  1  synchronous active-high reset
enable_i  in  1  decoder enable; low forces state SYNC and holds the FIFO
din_i  in  1  LED data line, asynchronous (from mprj_io)
cfg_min_high_i  in  CNT_W  high pulses shorter than this (cycles) are glitches
cfg_bit_thresh_i  in  CNT_W  high width at or below this is 0; above is 1
cfg_max_high_i  in  CNT_W  high width above this is a timing error
cfg_reset_cycles_i  in  CNT_W  low width at or above this ends the frame
clr_err_i  in  1  pulse; clears the sticky error flags
pix_data_o  out  24  pixel word, first-received bit at [23]
pix_first_o  out  1  word is the first pixel of its frame
pix_valid_o  out  1  FIFO head valid
pix_ready_i  in  1  consumer accepts the head word
frame_done_o  out  1  1-cycle pulse at frame end when at least 1 pixel was received
err_timing_o  out  1  sticky: glitch or over-long high pulse
err_partial_o  out  1  sticky: frame ended with 0 < bit count < 24
err_overflow_o  out  1  sticky: word dropped because the FIFO was full

Behaviour:
- Reset value of every output is 0. Reset also empties the FIFO, clears the counters, and sets the state to SYNC.
- din_i passes through a 2-flop synchroniser, then an edge-detect register. The "sampled" edge is the edge seen at the synchroniser output.
- State SYNC: wait until the line has been low for cfg_reset_cycles_i consecutive cycles, then go to IDLE. A rise before that restarts the low count.
- State IDLE/LOW: low counter runs and saturates at all-ones.
  - A rising edge goes to HIGH, clears the high counter, and clears the low counter.
  - If the low count reaches cfg_reset_cycles_i: end of frame. If bit_cnt is nonzero, discard the partial word and set err_partial. Pulse frame_done_o if at least one word was pushed this frame. Set first_pending=1.
- State HIGH: high counter increments and saturates.
  - If the count exceeds cfg_max_high_i while still high: set err_timing, discard the partial word, go to SYNC.
  - On a falling edge with h < cfg_min_high_i: set err_timing, ignore the bit, stay in frame.
  - On a falling edge with h <= cfg_bit_thresh_i: shift in 0. If h is greater: shift in 1. Go to LOW.
- Shifting is MSB first. When bit_cnt reaches 24, push {first_pending, word}, clear first_pending, and reset bit_cnt to 0.
- Latency: a pushed word appears on pix_valid_o 4 cycles after the falling edge of its 24th bit reaches the first synchroniser flop. Breakdown: 2 synchroniser + 1 edge + 1 FIFO write.
- FIFO: show-ahead. Head data is stable while pix_valid_o=1 and pix_ready_i=0.
  - Push while full with no pop in the same cycle: word dropped, err_overflow set.
  - Push and pop in the same cycle while full: both take effect, no overflow.
- Sticky errors clear only on clr_err_i or reset. If a set condition occurs in the same cycle as clr_err_i, the set wins.
- enable_i=0: state goes to SYNC, the partial word is discarded, no error is flagged. FIFO contents are retained and can still be popped.
- Config inputs are sampled every cycle and must be changed only while enable_i=0. Required ordering: cfg_min_high < cfg_bit_thresh < cfg_max_high < cfg_reset_cycles.

Decomposition:
- Package string_led_pkg:
  - state enum {SYNC, IDLE, LOW, HIGH}
  - BITS_PER_LED
  - default cfg constants for 40 MHz: min 4, thresh 24, max 48, reset 2000
- Submodule string_led_fifo: synchronous show-ahead FIFO, parameterised on width and depth. It provides full/empty flags and simultaneous push/pop.

Test Plan:
- Test cfg values: min 4, thresh 24, max 48, reset 200. Sequence: 300-cycle low, then 24 bits of 0xA5C31E with 16-cycle highs for 0 and 32-cycle highs for 1, then a 200-cycle low. Required: pix_data_o=0xA5C31E with pix_first_o=1, one frame_done_o pulse, no error flags.
- Back-to-back frame of 3 pixels 0x000001, 0xFFFFFF, 0x800000, then a reset low. Required: 3 words in order, pix_first_o set only on the first, a single frame_done_o pulse.
- 10 bits followed by a reset low. Required: err_partial_o=1, no word pushed, no frame_done_o. Then clr_err_i clears the flag.
- A 2-cycle glitch high inside a word. Required: err_timing_o=1 and the following valid bits still complete the word. A separate 60-cycle high must set err_timing_o, enter SYNC, and drop the partial word.
- Hold pix_ready_i=0 and send 5 pixels. Required: 4 words held in the FIFO, the 5th dropped, err_overflow_o=1. Then pop while a 6th word is pushed on a full FIFO: it is accepted and no new overflow is flagged.
- Pulse wb_rst_i mid-word (after bit 12). Required: all outputs 0 and FIFO empty. The next word is accepted only after a full cfg_reset_cycles_i low.
